// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the ARM-style pipeline stages.
//   id_ex_ctrl_t        decode-to-execute control bundle
//   ID_EX_CTRL_BUBBLE   all-zero control word (no write enables, Cond=EQ)
package pipeline_pkg;

    localparam int ALU_CTRL_W = 4;
    localparam int COND_W     = 4;
    localparam int REG_ADDR_W = 4;
    localparam int FLAGS_W    = 4;

    typedef struct packed {
        logic                  PCSrc;
        logic                  RegWrite;
        logic                  MemtoReg;
        logic                  MemWrite;
        logic                  Branch;
        logic                  ALUSrc;
        logic [ALU_CTRL_W-1:0] ALUControl;
        logic [1:0]            FlagWrite;
        logic [COND_W-1:0]     Cond;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

    // A bubble carries no write enables, so a Cond of EQ has no effect
    localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_clr.sv
// pipe_reg_clr: generic W-bit pipeline register.
//   clk, rst (async, active-high), clr (sync clear, wins over en),
//   en (load enable, hold when 0), d (next value), q (registered value)
module pipe_reg_clr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // State register: reset, then clear, then load, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {W{1'b0}};
        end else if (clr) begin
            r_q <= {W{1'b0}};
        end else if (en) begin
            r_q <= d;
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/decode_execute_register.sv
// decode_execute_register: ID/EX pipeline register with stall, flush and a
// per-entry valid bit.
//   clk, rst (async, active-high)
//   StallE  hold every E-stage output
//   FlushE  replace the entry with a bubble (wins over StallE)
//   CtrlD/FlagsD/RD1D/RD2D/ExtImmD/WA3D/RA1D/RA2D  decode-side inputs
//   CtrlE/FlagsE/RD1E/RD2E/ExtImmE/WA3E/RA1E/RA2E  registered E-side outputs
//   ValidE  entry holds a real instruction
//   StallCntE/FlushCntE  saturating performance counters
// Build option: define ID_EX_PERF_COUNTERS_EN to build the counters;
// otherwise both counter ports are tied to zero.
module decode_execute_register
    import pipeline_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  id_ex_ctrl_t           CtrlD,
    input  logic [FLAGS_W-1:0]    FlagsD,
    input  logic [N-1:0]          RD1D,
    input  logic [N-1:0]          RD2D,
    input  logic [N-1:0]          ExtImmD,
    input  logic [REG_ADDR_W-1:0] WA3D,
    input  logic [REG_ADDR_W-1:0] RA1D,
    input  logic [REG_ADDR_W-1:0] RA2D,
    output id_ex_ctrl_t           CtrlE,
    output logic [FLAGS_W-1:0]    FlagsE,
    output logic [N-1:0]          RD1E,
    output logic [N-1:0]          RD2E,
    output logic [N-1:0]          ExtImmE,
    output logic [REG_ADDR_W-1:0] WA3E,
    output logic [REG_ADDR_W-1:0] RA1E,
    output logic [REG_ADDR_W-1:0] RA2E,
    output logic                  ValidE,
    output logic [CNT_W-1:0]      StallCntE,
    output logic [CNT_W-1:0]      FlushCntE
);

    localparam int ADDR3_W = 3 * REG_ADDR_W;

    logic               w_en;
    logic [CTRL_W-1:0]  w_ctrl_q;
    logic [ADDR3_W-1:0] w_addr_q;

    assign w_en = ~StallE;

    pipe_reg_clr #(.W(CTRL_W)) u_ctrl (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d(CtrlD), .q(w_ctrl_q)
    );
    assign CtrlE = id_ex_ctrl_t'(w_ctrl_q);

    pipe_reg_clr #(.W(FLAGS_W)) u_flags (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d(FlagsD), .q(FlagsE)
    );

    pipe_reg_clr #(.W(N)) u_rd1 (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d(RD1D), .q(RD1E)
    );

    pipe_reg_clr #(.W(N)) u_rd2 (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d(RD2D), .q(RD2E)
    );

    pipe_reg_clr #(.W(N)) u_imm (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d(ExtImmD), .q(ExtImmE)
    );

    // The three register addresses travel together for the forwarding unit
    pipe_reg_clr #(.W(ADDR3_W)) u_addr (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d({WA3D, RA1D, RA2D}), .q(w_addr_q)
    );
    assign {WA3E, RA1E, RA2E} = w_addr_q;

    // Valid loads a constant 1, so a flush leaves 0 and a stall holds
    pipe_reg_clr #(.W(1)) u_valid (
        .clk(clk), .rst(rst), .clr(FlushE), .en(w_en),
        .d(1'b1), .q(ValidE)
    );

`ifdef ID_EX_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Event counters: a flush counts as a flush only, even when stalled too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else if (FlushE) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
        end else if (StallE) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign StallCntE = r_stall_cnt;
    assign FlushCntE = r_flush_cnt;
`else
    assign StallCntE = {CNT_W{1'b0}};
    assign FlushCntE = {CNT_W{1'b0}};
`endif

endmodule
